// File: rtl/neu_pkg.sv
// Shared definitions for the grid path-cost node: compass encodings,
// direction-word layout, default step costs and all-ones helpers.
package neu_pkg;

   // Compass encoding used in the low three bits of path_dir.
   typedef enum logic [2:0] {
      DIR_N  = 3'd0,
      DIR_NE = 3'd1,
      DIR_E  = 3'd2,
      DIR_SE = 3'd3,
      DIR_S  = 3'd4,
      DIR_SW = 3'd5,
      DIR_W  = 3'd6,
      DIR_NW = 3'd7
   } compass_e;

   // Bit of path_dir that marks a valid direction.
   localparam int DIR_VALID = 3;

   // Default step costs in half-units.
   localparam int DEF_PERP_COST = 2;
   localparam int DEF_DIAG_COST = 3;

   // Mask with the low w bits set (w up to 32).
   function automatic logic [31:0] ones_mask(input int unsigned w);
      logic [31:0] m;
      if (w >= 32) begin
         m = 32'hFFFF_FFFF;
      end else begin
         m = (32'd1 << w) - 32'd1;
      end
      return m;
   endfunction

   // True when the low w bits of v are all ones.
   function automatic logic all_ones(input logic [31:0] v, input int unsigned w);
      logic [31:0] m;
      m = ones_mask(w);
      return ((v & m) == m);
   endfunction

   // A cost of all ones means the cell has not been reached yet.
   function automatic logic is_unreached(input logic [31:0] cost, input int unsigned w);
      return all_ones(cost, w);
   endfunction

   // A weight of all ones means the cell cannot be entered.
   function automatic logic is_inaccessible(input logic [31:0] weight, input int unsigned w);
      return all_ones(weight, w);
   endfunction

endpackage

// File: rtl/neu_lane_min.sv
// Balanced compare tree over LANES candidate travel costs. Returns the
// smallest valid value, the lane it came from (lowest lane on ties) and
// whether any lane was valid at all. LANES must be a power of two.
module neu_lane_min
   import neu_pkg::*;
#(
   parameter int VAL_W = 13,
   parameter int LANES = 1,
   parameter int IDX_W = 1
) (
   input  logic [LANES*VAL_W-1:0] vals,
   input  logic [LANES-1:0]       valid,
   output logic [VAL_W-1:0]       min_val,
   output logic [IDX_W-1:0]       min_idx,
   output logic                   any_valid
);

   // Heap-ordered tree: node 1 is the root, leaves sit at LANES..2*LANES-1.
   logic [VAL_W-1:0] node_val_s [1:2*LANES-1];
   logic [IDX_W-1:0] node_idx_s [1:2*LANES-1];
   logic             node_ok_s  [1:2*LANES-1];

   // Load the leaves, then reduce pairwise toward the root preferring the left child.
   always_comb begin
      logic pick_right_v;
      pick_right_v = 1'b0;
      for (int i = 1; i < 2*LANES; i++) begin
         node_val_s[i] = '0;
         node_idx_s[i] = '0;
         node_ok_s[i]  = 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
         node_val_s[LANES+i] = vals[i*VAL_W +: VAL_W];
         node_idx_s[LANES+i] = IDX_W'(i);
         node_ok_s[LANES+i]  = valid[i];
      end
      for (int i = LANES-1; i >= 1; i--) begin
         pick_right_v = node_ok_s[2*i+1] &&
                        (!node_ok_s[2*i] || (node_val_s[2*i+1] < node_val_s[2*i]));
         if (pick_right_v) begin
            node_val_s[i] = node_val_s[2*i+1];
            node_idx_s[i] = node_idx_s[2*i+1];
         end else begin
            node_val_s[i] = node_val_s[2*i];
            node_idx_s[i] = node_idx_s[2*i];
         end
         node_ok_s[i] = node_ok_s[2*i] | node_ok_s[2*i+1];
      end
   end

   assign min_val   = node_val_s[1];
   assign min_idx   = node_idx_s[1];
   assign any_valid = node_ok_s[1];

endmodule

// File: rtl/neu_gen.sv
// Grid path-cost node. Each relax cycle evaluates LANES neighbours of the
// current group, keeps the cheapest route if it beats the stored cost, and
// tracks sweep completion and stability for the array controller.
module neu_gen
   import neu_pkg::*;
#(
   parameter int COST_W    = 12,
   parameter int WEIGHT_W  = 4,
   parameter int NBR       = 8,
   parameter int LANES     = 1,
   parameter int PERP_COST = DEF_PERP_COST,
   parameter int DIAG_COST = DEF_DIAG_COST
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  ld,
   input  logic [WEIGHT_W-1:0]   ld_weight,
   input  logic                  en,
   input  logic [NBR*COST_W-1:0] nbr_cost,
   output logic [COST_W-1:0]     path_cost,
   output logic [3:0]            path_dir,
   output logic                  path_mod,
   output logic                  sweep_done,
   output logic                  stable
);

   localparam int GRPS    = NBR / LANES;
   localparam int GRP_W   = (GRPS > 1) ? $clog2(GRPS) : 1;
   localparam int QUIET_W = $clog2(GRPS + 1);
   localparam int VAL_W   = COST_W + 1;
   localparam int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;

   logic [COST_W-1:0]   cost_r;
   logic [3:0]          dir_r;
   logic [WEIGHT_W-1:0] weight_r;
   logic [GRP_W-1:0]    grp_r;
   logic [QUIET_W-1:0]  quiet_r;
   logic                path_mod_r;
   logic                sweep_done_r;
   logic                stable_r;

   logic [LANES*VAL_W-1:0] lane_val_s;
   logic [LANES-1:0]       lane_ok_s;
   logic [VAL_W-1:0]       min_val_s;
   logic [IDX_W-1:0]       min_idx_s;
   logic                   any_valid_s;
   logic                   inacc_s;
   logic                   update_s;
   logic [3:0]             dir_nxt_s;
   logic [GRP_W-1:0]       grp_nxt_s;
   logic                   grp_last_s;
   logic [QUIET_W-1:0]     quiet_inc_s;

   // Per-lane travel cost: neighbour + doubled weight + step, one bit wider to catch overflow.
   always_comb begin
      int               k_v;
      logic [COST_W-1:0] nbr_v;
      logic [VAL_W-1:0]  step_v;
      logic [VAL_W-1:0]  trav_v;
      k_v        = 0;
      nbr_v      = '0;
      step_v     = '0;
      trav_v     = '0;
      lane_val_s = '0;
      lane_ok_s  = '0;
      for (int j = 0; j < LANES; j++) begin
         k_v   = int'(grp_r) * LANES + j;
         nbr_v = nbr_cost[k_v*COST_W +: COST_W];
         if ((NBR == 8) && k_v[0]) begin
            step_v = VAL_W'(DIAG_COST);
         end else begin
            step_v = VAL_W'(PERP_COST);
         end
         trav_v = {1'b0, nbr_v} + (VAL_W'(weight_r) << 1) + step_v;
         lane_val_s[j*VAL_W +: VAL_W] = trav_v;
         lane_ok_s[j] = !trav_v[COST_W] && !is_unreached(32'(nbr_v), COST_W);
      end
   end

   neu_lane_min #(
      .VAL_W (VAL_W),
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_lane_min (
      .vals      (lane_val_s),
      .valid     (lane_ok_s),
      .min_val   (min_val_s),
      .min_idx   (min_idx_s),
      .any_valid (any_valid_s)
   );

   // Decide whether the winning lane improves the cost and form the new direction word.
   always_comb begin
      int win_k_v;
      win_k_v   = int'(grp_r) * LANES + int'(min_idx_s);
      inacc_s   = is_inaccessible(32'(weight_r), WEIGHT_W);
      update_s  = any_valid_s && (min_val_s < {1'b0, cost_r});
      dir_nxt_s = '0;
      if (NBR == 8) begin
         dir_nxt_s[2:0] = 3'(win_k_v);
      end else begin
         dir_nxt_s[2:0] = 3'(win_k_v * 2);
      end
      dir_nxt_s[DIR_VALID] = 1'b1;
   end

   // Group counter wrap and saturating quiet-cycle increment.
   always_comb begin
      grp_last_s = (grp_r == GRP_W'(GRPS - 1));
      if (grp_last_s) begin
         grp_nxt_s = '0;
      end else begin
         grp_nxt_s = grp_r + GRP_W'(1);
      end
      if (quiet_r >= QUIET_W'(GRPS)) begin
         quiet_inc_s = quiet_r;
      end else begin
         quiet_inc_s = quiet_r + QUIET_W'(1);
      end
   end

   // Node state: reset, then source/weight control, then hold, freeze or relax.
   always_ff @(posedge clk) begin
      if (rst) begin
         cost_r       <= '1;
         dir_r        <= '0;
         weight_r     <= '1;
         grp_r        <= '0;
         quiet_r      <= '0;
         path_mod_r   <= 1'b0;
         sweep_done_r <= 1'b0;
         stable_r     <= 1'b0;
      end else if (clr || ld) begin
         if (clr) begin
            cost_r     <= '0;
            dir_r      <= '0;
            path_mod_r <= 1'b1;
         end else begin
            path_mod_r <= 1'b0;
         end
         if (ld) begin
            weight_r <= ld_weight;
         end
         quiet_r      <= '0;
         stable_r     <= 1'b0;
         sweep_done_r <= 1'b0;
      end else if (!en) begin
         path_mod_r   <= 1'b0;
         sweep_done_r <= 1'b0;
      end else if (inacc_s) begin
         path_mod_r   <= 1'b0;
         sweep_done_r <= 1'b0;
         stable_r     <= 1'b1;
      end else begin
         grp_r        <= grp_nxt_s;
         sweep_done_r <= grp_last_s;
         if (update_s) begin
            cost_r     <= min_val_s[COST_W-1:0];
            dir_r      <= dir_nxt_s;
            path_mod_r <= 1'b1;
            quiet_r    <= '0;
            stable_r   <= 1'b0;
         end else begin
            path_mod_r <= 1'b0;
            quiet_r    <= quiet_inc_s;
            stable_r   <= (quiet_inc_s >= QUIET_W'(GRPS));
         end
      end
   end

   assign path_cost  = cost_r;
   assign path_dir   = dir_r;
   assign path_mod   = path_mod_r;
   assign sweep_done = sweep_done_r;
   assign stable     = stable_r;

endmodule

// File: tb/tb_neu_gen.sv
// Directed bench for neu_gen. Three instances (8-nbr/1-lane, 8-nbr/4-lane,
// 4-nbr/1-lane) share control inputs; each phase checks the relevant ones.
module tb_neu_gen;
   import neu_pkg::*;

   logic clk = 1'b0;
   logic rst, clr, ld, en;
   logic [3:0] ld_weight;
   logic [8*12-1:0] nbr_a, nbr_b;
   logic [4*12-1:0] nbr_c;

   logic [11:0] cost_a, cost_b, cost_c;
   logic [3:0]  dir_a, dir_b, dir_c;
   logic        pm_a, pm_b, pm_c, sd_a, sd_b, sd_c, st_a, st_b, st_c;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   neu_gen #(.COST_W(12), .WEIGHT_W(4), .NBR(8), .LANES(1), .PERP_COST(2), .DIAG_COST(3)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
      .nbr_cost(nbr_a), .path_cost(cost_a), .path_dir(dir_a), .path_mod(pm_a),
      .sweep_done(sd_a), .stable(st_a));

   neu_gen #(.COST_W(12), .WEIGHT_W(4), .NBR(8), .LANES(4), .PERP_COST(2), .DIAG_COST(3)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
      .nbr_cost(nbr_b), .path_cost(cost_b), .path_dir(dir_b), .path_mod(pm_b),
      .sweep_done(sd_b), .stable(st_b));

   neu_gen #(.COST_W(12), .WEIGHT_W(4), .NBR(4), .LANES(1), .PERP_COST(2), .DIAG_COST(3)) dut_c (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
      .nbr_cost(nbr_c), .path_cost(cost_c), .path_dir(dir_c), .path_mod(pm_c),
      .sweep_done(sd_c), .stable(st_c));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; ld_weight = 4'd0;
      nbr_a = '1; nbr_b = '1; nbr_c = '1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_val("rst_cost", 32'(cost_a), 32'd4095);
      check_val("rst_dir", 32'(dir_a), 32'd0);
      check_val("rst_pm", 32'(pm_a), 32'd0);
      check_val("rst_sd", 32'(sd_a), 32'd0);
      check_val("rst_stable", 32'(st_a), 32'd0);

      // Weight 0: overflow on A, tie-break on B, 4-nbr mapping on C
      ld = 1'b1; ld_weight = 4'd0;
      tick();
      ld = 1'b0;
      nbr_a[0*12 +: 12] = 12'd4094;
      nbr_b[0*12 +: 12] = 12'd10;
      nbr_b[2*12 +: 12] = 12'd10;
      nbr_c[3*12 +: 12] = 12'd0;
      en = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check_val("ovf_cost", 32'(cost_a), 32'd4095);
         check_val("ovf_pm", 32'(pm_a), 32'd0);
         check_val("ovf_stable", 32'(st_a), (t == 8) ? 32'd1 : 32'd0);
         check_val("tie_cost", 32'(cost_b), 32'd12);
         check_val("tie_dir", 32'(dir_b), 32'b1000);
         check_val("tie_pm", 32'(pm_b), (t == 1) ? 32'd1 : 32'd0);
         check_val("tie_sd", 32'(sd_b), (t % 2 == 0) ? 32'd1 : 32'd0);
         check_val("tie_stable", 32'(st_b), (t >= 3) ? 32'd1 : 32'd0);
         check_val("n4_cost", 32'(cost_c), (t >= 4) ? 32'd2 : 32'd4095);
         check_val("n4_dir", 32'(dir_c), (t >= 4) ? 32'b1110 : 32'd0);
         check_val("n4_pm", 32'(pm_c), (t == 4) ? 32'd1 : 32'd0);
         check_val("n4_sd", 32'(sd_c), (t == 4 || t == 8) ? 32'd1 : 32'd0);
         check_val("n4_stable", 32'(st_c), (t == 8) ? 32'd1 : 32'd0);
      end

      // Inaccessible cell: weight 15, neighbours 0
      do_reset();
      nbr_a = '0;
      ld = 1'b1; ld_weight = 4'd15;
      tick();
      ld = 1'b0;
      check_val("inacc_ld_stable", 32'(st_a), 32'd0);
      for (int t = 0; t < 3; t++) begin
         tick();
         check_val("inacc_cost", 32'(cost_a), 32'd4095);
         check_val("inacc_dir", 32'(dir_a), 32'd0);
         check_val("inacc_stable", 32'(st_a), 32'd1);
         check_val("inacc_pm", 32'(pm_a), 32'd0);
      end

      // 8-neighbour relaxation order, weight 1
      en = 1'b0;
      do_reset();
      ld = 1'b1; ld_weight = 4'd1;
      tick();
      ld = 1'b0;
      nbr_a = '1;
      nbr_a[0*12 +: 12] = 12'd10;
      nbr_a[1*12 +: 12] = 12'd6;
      nbr_a[2*12 +: 12] = 12'd5;
      en = 1'b1;
      tick();
      check_val("ord1_cost", 32'(cost_a), 32'd14);
      check_val("ord1_dir", 32'(dir_a), {28'd0, 1'b1, DIR_N});
      check_val("ord1_pm", 32'(pm_a), 32'd1);
      tick();
      check_val("ord2_cost", 32'(cost_a), 32'd11);
      check_val("ord2_dir", 32'(dir_a), {28'd0, 1'b1, DIR_NE});
      check_val("ord2_pm", 32'(pm_a), 32'd1);
      tick();
      check_val("ord3_cost", 32'(cost_a), 32'd9);
      check_val("ord3_dir", 32'(dir_a), {28'd0, 1'b1, DIR_E});
      check_val("ord3_pm", 32'(pm_a), 32'd1);
      for (int t = 4; t <= 11; t++) begin
         tick();
         check_val("quiet_cost", 32'(cost_a), 32'd9);
         check_val("quiet_pm", 32'(pm_a), 32'd0);
         check_val("quiet_sd", 32'(sd_a), (t == 8) ? 32'd1 : 32'd0);
         check_val("quiet_stable", 32'(st_a), (t == 11) ? 32'd1 : 32'd0);
      end

      // en low for 5 cycles: nothing moves even with a better neighbour
      en = 1'b0;
      nbr_a[0*12 +: 12] = 12'd0;
      for (int t = 0; t < 5; t++) begin
         tick();
         check_val("hold_cost", 32'(cost_a), 32'd9);
         check_val("hold_dir", 32'(dir_a), 32'b1010);
         check_val("hold_pm", 32'(pm_a), 32'd0);
         check_val("hold_sd", 32'(sd_a), 32'd0);
         check_val("hold_stable", 32'(st_a), 32'd1);
      end

      // Resume: group counter held at 3, so SE is evaluated next
      nbr_a[0*12 +: 12] = 12'd10;
      nbr_a[3*12 +: 12] = 12'd0;
      en = 1'b1;
      tick();
      check_val("resume_cost", 32'(cost_a), 32'd5);
      check_val("resume_dir", 32'(dir_a), {28'd0, 1'b1, DIR_SE});
      check_val("resume_pm", 32'(pm_a), 32'd1);
      check_val("resume_stable", 32'(st_a), 32'd0);

      // clr and ld together mid-sweep with en high
      clr = 1'b1; ld = 1'b1; ld_weight = 4'd15;
      tick();
      clr = 1'b0; ld = 1'b0;
      check_val("clrld_cost", 32'(cost_a), 32'd0);
      check_val("clrld_dir", 32'(dir_a), 32'd0);
      check_val("clrld_pm", 32'(pm_a), 32'd1);
      check_val("clrld_stable", 32'(st_a), 32'd0);
      check_val("clrld_sd", 32'(sd_a), 32'd0);
      tick();
      check_val("clrld_wt_stable", 32'(st_a), 32'd1);
      check_val("clrld_wt_pm", 32'(pm_a), 32'd0);
      check_val("clrld_wt_cost", 32'(cost_a), 32'd0);

      // rst mid-sweep with en high
      rst = 1'b1;
      tick();
      check_val("rstmid_cost", 32'(cost_a), 32'd4095);
      check_val("rstmid_dir", 32'(dir_a), 32'd0);
      check_val("rstmid_stable", 32'(st_a), 32'd0);
      check_val("rstmid_pm", 32'(pm_a), 32'd0);
      rst = 1'b0;
      ld = 1'b1; ld_weight = 4'd1;
      nbr_a = '1;
      nbr_a[0*12 +: 12] = 12'd10;
      tick();
      ld = 1'b0;
      tick();
      check_val("rstmid_grp0_cost", 32'(cost_a), 32'd14);
      check_val("rstmid_grp0_dir", 32'(dir_a), 32'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/neu_gen.md
# neu_gen

Parametrised node execution unit for the grid path-cost solver. It is the next-generation replacement for the fixed 8-neighbour, one-neighbour-per-cycle node. Cost width, weight width, connectivity (4 or 8) and the number of neighbours evaluated per cycle (lanes) are all configurable, and it adds run enable, registered change flags, sweep and stability reporting. One instance sits at each grid cell; the array controller watches `path_mod`/`stable` to detect convergence.

## Interface
- `COST_W`, 12: cost width; all-ones means unreached.
- `WEIGHT_W`, 4: cell weight width; all-ones means inaccessible.
- `NBR`, 8: neighbour count, 4 or 8.
- `LANES`, 1: neighbours evaluated per cycle; must be 1, 2, 4 or 8, must divide `NBR`, and must not exceed `NBR`.
- `PERP_COST`, 2: step cost for orthogonal moves (half-units).
- `DIAG_COST`, 3: step cost for diagonal moves (half-units).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: make this cell a source (cost 0).
- `ld` in 1: load `ld_weight`.
- `ld_weight` in `WEIGHT_W`: weight value.
- `en` in 1: run relaxation; low holds all state.
- `nbr_cost` in `NBR*COST_W`: neighbour costs, slice k = neighbour k.
  - NBR=8 order: N, NE, E, SE, S, SW, W, NW.
  - NBR=4 order: N, E, S, W.
- `path_cost` out `COST_W`: current cost.
- `path_dir` out 4: `{valid, compass[2:0]}`; compass 0=N … 7=NW.
- `path_mod` out 1: registered; high for one cycle when `path_cost` just decreased.
- `sweep_done` out 1: one-cycle pulse when the last neighbour group was evaluated.
- `stable` out 1: a full sweep has completed with no change.

## Operation
- Reset values:
  - `cost` = all-ones, `dir` = 0, `weight` = all-ones (inaccessible).
  - `grp` = 0.
  - `path_mod` = 0, `sweep_done` = 0, `stable` = 0, `quiet` = 0.
- Priority is rst > clr > ld > relax. When clr or ld is active, no relaxation happens that cycle.
- clr:
  - Sets cost to 0 and dir to 0.
  - Clears `stable` and `quiet`.
  - Sets `path_mod` = 1 on the next cycle.
- ld: loads the weight, clears `stable` and `quiet`. It does not touch cost.
- Counter `grp`: 0 .. `NBR/LANES`-1. While relaxing it advances by 1 per cycle and wraps to 0. Lane j in group g is neighbour g*`LANES`+j.
- Relax cycle: requires `en`=1, weight ≠ all-ones, and none of rst/clr/ld. For each lane:
  - `travel` = nbr + (weight<<1) + step, computed at `COST_W`+1 bits.
  - step = `DIAG_COST` for odd k when NBR=8; otherwise `PERP_COST`.
  - A lane is discarded if `travel[COST_W]` is set or if nbr is all-ones.
- Lane reduction:
  - Select the minimum surviving travel; ties go to the lowest lane.
  - If minimum < cost (strict): cost ← minimum, dir ← {1, compass}. compass = k for NBR=8, 2k for NBR=4.
- Stability:
  - `quiet` counts consecutive relax cycles with no update. Any update resets it to 0.
  - `stable` = (`quiet` ≥ `NBR/LANES`).
- Inaccessible cell (weight all-ones):
  - cost, dir and grp are frozen.
  - `path_mod` = 0, `sweep_done` = 0, `stable` = 1.
- `en`=0: all registers hold. `path_mod` and `sweep_done` are 0.

## Timing
- Latency: the neighbour value sampled in cycle t appears on `path_cost`/`path_dir` at t+1, with `path_mod`=1 at t+1.
- `sweep_done` is asserted at t+1 when group `NBR/LANES`-1 was evaluated at t.
- With `LANES`=`NBR`, every cycle is a full sweep and `sweep_done` is high on every relax cycle.
- Reset mid-sweep: all state returns to reset values at the next edge; the sweep restarts at group 0.
- All outputs are registers; there are no combinational input-to-output paths.

## Structure
- Package `neu_pkg`:
  - Compass encodings `DIR_N`..`DIR_NW`.
  - `DIR_VALID` bit position.
  - Default `PERP_COST`/`DIAG_COST`.
  - Unreached/inaccessible all-ones helper functions.
- Sub-module `neu_lane_min`: parametrised `LANES`-input compare tree. Outputs the minimum value, the winning lane index and an any-valid flag.

## Test plan
- **8-neighbour relaxation order** (NBR=8, LANES=1, weight 1):
  - Stimulus: N=10, NE=6, E=5, others 4095; en high.
  - cost → 14 (dir 1000), then 11 (dir 1001), then 9 (dir 1010), with one `path_mod` pulse each.
  - `stable`=1 after 8 further quiet cycles.
- **Overflow discard:** weight 0, N=4094 (travel 4096). Cost stays 4095, `path_mod` never asserts.
- **Inaccessible cell:** ld weight 15, neighbours 0.
  - cost stays 4095, dir 0, `stable`=1, `path_mod`=0.
- **Lane tie-break** (LANES=4, weight 0):
  - Stimulus: N=10, E=10.
  - At cycle 1, cost=12, dir=1000 (lowest lane wins).
  - `sweep_done` pulses every 2nd cycle.
  - `stable` rises after 2 quiet cycles.
- **4-neighbour mapping** (NBR=4): W=0, weight 0 → cost 2, dir 1110.
- **Priority and control:**
  - clr and ld asserted together with en mid-sweep: cost=0, weight loaded, no relaxation that cycle.
  - rst mid-sweep: cost=4095, grp=0, `stable`=0.
  - en low for 5 cycles: no outputs change.
